game_sprite_motion_unit: RTL

//  Sprite-side responder to the game master FSM strobes write_xy / write_dxy / enable_update.

---
 rtl/game_sprite_motion_unit_if.sv | 34 +++
 rtl/game_sprite_motion_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/game_sprite_motion_unit_if.sv
// Sprite motion bus: control strobes and raster inputs from the game master,
// and sprite position and status flags back to it.
interface game_sprite_motion_unit_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10,
    parameter int D_W = 4
);
    logic                  write_xy;
    logic                  write_dxy;
    logic                  enable_update;
    logic [X_W-1:0]        write_x;
    logic [Y_W-1:0]        write_y;
    logic signed [D_W-1:0] write_dx;
    logic signed [D_W-1:0] write_dy;
    logic                  frame_start;
    logic [X_W-1:0]        pixel_x;
    logic [Y_W-1:0]        pixel_y;
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic                  within_screen;
    logic                  hit;

    modport master (
        output write_xy, write_dxy, enable_update, write_x, write_y,
               write_dx, write_dy, frame_start, pixel_x, pixel_y,
        input  x, y, within_screen, hit
    );

    modport slave (
        input  write_xy, write_dxy, enable_update, write_x, write_y,
               write_dx, write_dy, frame_start, pixel_x, pixel_y,
        output x, y, within_screen, hit
    );
endinterface

// File: rtl/game_sprite_motion_unit.sv
// One sprite's position/velocity, stepped once per STRIDE enabled frames, with
// screen-containment and raster-hit flags. Define GAME_SPRITE_BOUNCE_EN to bounce off edges.
module game_sprite_motion_unit #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int D_W      = 4,
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int STRIDE   = 2,
    parameter int START_X  = 0,
    parameter int START_Y  = 0,
    parameter int START_DX = 0,
    parameter int START_DY = 0
) (
    input logic                     clk,
    input logic                     rst,
    game_sprite_motion_unit_if.slave bus
);
    localparam int CNT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    typedef enum logic [1:0] {HOLD, WAIT, STEP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      frame_cnt;
    logic [X_W-1:0]        x_q;
    logic [Y_W-1:0]        y_q;
    logic signed [D_W-1:0] dx_q;
    logic signed [D_W-1:0] dy_q;
    logic                  off_x;
    logic                  off_y;
    logic                  within_q;
    logic                  hit_q;

    logic signed [X_W:0]   sum_x;
    logic signed [Y_W:0]   sum_y;
    logic                  sum_x_off;
    logic                  sum_y_off;
    logic                  pix_in;
    logic                  within_next;

    // One guard bit above the position so a negative step result is visible before wrapping.
    always_comb begin
        sum_x     = $signed({1'b0, x_q}) + (X_W+1)'(dx_q);
        sum_y     = $signed({1'b0, y_q}) + (Y_W+1)'(dy_q);
        sum_x_off = sum_x[X_W] | (int'(sum_x[X_W-1:0]) + SPRITE_W > SCREEN_W);
        sum_y_off = sum_y[Y_W] | (int'(sum_y[Y_W-1:0]) + SPRITE_H > SCREEN_H);
        pix_in    = (bus.pixel_x >= x_q) & (int'(bus.pixel_x) < int'(x_q) + SPRITE_W) &
                    (bus.pixel_y >= y_q) & (int'(bus.pixel_y) < int'(y_q) + SPRITE_H);
`ifdef GAME_SPRITE_BOUNCE_EN
        within_next = ~off_x & ~off_y;
`else
        within_next = ~off_x & ~off_y &
                      (int'(x_q) + SPRITE_W <= SCREEN_W) & (int'(y_q) + SPRITE_H <= SCREEN_H);
`endif
    end

    // NOTE: every register here, state included, is written with <= so all of them
    // update together on the edge and read their pre-edge values in this block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HOLD;
            frame_cnt <= '0;
            x_q       <= X_W'(START_X);
            y_q       <= Y_W'(START_Y);
            dx_q      <= D_W'(START_DX);
            dy_q      <= D_W'(START_DY);
            off_x     <= 1'b0;
            off_y     <= 1'b0;
            within_q  <= 1'b1;
            hit_q     <= 1'b0;
        end else begin
            within_q <= within_next;
            hit_q    <= pix_in & within_q;

            // A load in the step cycle wins; the step is simply lost.
            if (bus.write_xy) begin
                x_q   <= bus.write_x;
                y_q   <= bus.write_y;
                off_x <= 1'b0;
                off_y <= 1'b0;
            end else if (state == STEP) begin
`ifdef GAME_SPRITE_BOUNCE_EN
                if (!sum_x_off) x_q <= sum_x[X_W-1:0];
                if (!sum_y_off) y_q <= sum_y[Y_W-1:0];
`else
                x_q <= sum_x[X_W-1:0];
                y_q <= sum_y[Y_W-1:0];
                if (sum_x_off) off_x <= 1'b1;
                if (sum_y_off) off_y <= 1'b1;
`endif
            end

            if (bus.write_dxy) begin
                dx_q <= bus.write_dx;
                dy_q <= bus.write_dy;
            end
`ifdef GAME_SPRITE_BOUNCE_EN
            else if (state == STEP && !bus.write_xy) begin
                if (sum_x_off) dx_q <= -dx_q;
                if (sum_y_off) dy_q <= -dy_q;
            end
`endif

            unique case (state)
                HOLD: begin
                    frame_cnt <= '0;
                    if (bus.enable_update) state <= WAIT;
                end
                WAIT: begin
                    if (!bus.enable_update) begin
                        state     <= HOLD;
                        frame_cnt <= '0;
                    end else if (bus.frame_start) begin
                        if (frame_cnt == CNT_W'(STRIDE - 1)) begin
                            state     <= STEP;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                STEP:    state <= bus.enable_update ? WAIT : HOLD;
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.x             = x_q;
    assign bus.y             = y_q;
    assign bus.within_screen = within_q;
    assign bus.hit           = hit_q;
endmodule
